// File: rtl/lock_alarm_ctrl.sv
// Lock/alarm controller: opens on a good code, locks out after repeated
// wrong codes, and times both states out on the tick timebase.
module lock_alarm_ctrl #(
  parameter int MAX_FAIL = 3,
  parameter int LOCK_SEC = 10,
  parameter int OPEN_SEC = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       attempt_valid,
  input  logic       attempt_ok,
  input  logic       tick,
  input  logic       relock,
  output logic       unlocked,
  output logic       alarm,
  output logic [1:0] fail_cnt,
  output logic [3:0] remaining
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic       unlocked_nx, alarm_nx;
  logic [1:0] fail_nx;
  logic [3:0] rem_nx;
  logic [2:0] fail_inc;

  assign fail_inc = {1'b0, fail_cnt} + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      unlocked  <= 1'b0;
      alarm     <= 1'b0;
      fail_cnt  <= 2'd0;
      remaining <= 4'd0;
    end else begin
      state     <= state_nx;
      unlocked  <= unlocked_nx;
      alarm     <= alarm_nx;
      fail_cnt  <= fail_nx;
      remaining <= rem_nx;
    end
  end

  always_comb begin
    state_nx    = IDLE;
    fail_nx     = 2'd0;
    rem_nx      = 4'd0;
    unlocked_nx = 1'b0;
    alarm_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        state_nx = IDLE;
        fail_nx  = fail_cnt;
        if (attempt_valid) begin
          if (attempt_ok) begin
            state_nx    = OPEN;
            rem_nx      = 4'(OPEN_SEC);
            fail_nx     = 2'd0;
            unlocked_nx = 1'b1;
          end else if (fail_inc >= 3'(MAX_FAIL)) begin
            state_nx = LOCKED;
            rem_nx   = 4'(LOCK_SEC);
            fail_nx  = 2'd0;
            alarm_nx = 1'b1;
          end else begin
            fail_nx = fail_inc[1:0];
          end
        end
      end
      OPEN: begin
        state_nx    = OPEN;
        rem_nx      = remaining;
        unlocked_nx = 1'b1;
        if (relock || (tick && remaining <= 4'd1)) begin
          state_nx    = IDLE;
          rem_nx      = 4'd0;
          unlocked_nx = 1'b0;
        end else if (tick) begin
          rem_nx = remaining - 4'd1;
        end
      end
      LOCKED: begin
        state_nx = LOCKED;
        rem_nx   = remaining;
        alarm_nx = 1'b1;
        if (tick && remaining <= 4'd1) begin
          state_nx = IDLE;
          rem_nx   = 4'd0;
          alarm_nx = 1'b0;
        end else if (tick) begin
          rem_nx = remaining - 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: doc/lock_alarm_ctrl.md
LOCK_ALARM_CTRL -- requirements
Module: lock_alarm_ctrl

Interface
REQ-001 Parameter MAX_FAIL, default 3, number of consecutive failed attempts that triggers lockout (range 1..3).
REQ-002 Parameter LOCK_SEC, default 10, lockout duration in tick periods (range 1..15).
REQ-003 Parameter OPEN_SEC, default 5, unlock duration in tick periods (range 1..15).
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 attempt_valid  input  1  one-cycle pulse from the code checker: a code entry has completed.
REQ-007 attempt_ok  input  1  qualifies attempt_valid: 1 = correct code, 0 = wrong code; ignored when attempt_valid=0.
REQ-008 tick  input  1  one-cycle timebase enable, nominally 1 Hz.
REQ-009 relock  input  1  one-cycle request to close the lock early.
REQ-010 unlocked  output  1  lock open, high only in state OPEN.
REQ-011 alarm  output  1  alarm/lockout indicator, high only in state LOCKED.
REQ-012 fail_cnt  output  2  consecutive wrong attempts seen in IDLE.
REQ-013 remaining  output  4  tick periods left in OPEN or LOCKED; 0 in IDLE.

Function
REQ-014 The block SHALL implement three states: IDLE, OPEN, LOCKED; all outputs SHALL be registered, updating the cycle after the causing input.
REQ-015 IDLE, attempt_valid=1, attempt_ok=1: next state OPEN, remaining<=OPEN_SEC, fail_cnt<=0.
REQ-016 IDLE, attempt_valid=1, attempt_ok=0, fail_cnt+1 < MAX_FAIL: stay IDLE, fail_cnt<=fail_cnt+1.
REQ-017 IDLE, attempt_valid=1, attempt_ok=0, fail_cnt+1 = MAX_FAIL: next state LOCKED, remaining<=LOCK_SEC, fail_cnt<=0.
REQ-018 In IDLE, tick and relock SHALL have no effect; remaining SHALL hold 0.
REQ-019 OPEN or LOCKED, tick=1 with remaining>1: remaining<=remaining-1, state held.
REQ-020 OPEN or LOCKED, tick=1 with remaining=1: next state IDLE, remaining<=0.
REQ-021 OPEN, relock=1: next state IDLE, remaining<=0, regardless of tick in the same cycle.
REQ-022 In LOCKED, relock SHALL be ignored; in OPEN and LOCKED, attempt_valid SHALL be ignored and fail_cnt SHALL stay 0.
REQ-023 The cycle of entry into OPEN or LOCKED SHALL NOT consume a tick even if tick=1 that cycle; the first decrement occurs on the next tick.
REQ-024 remaining SHALL never wrap below 0 nor exceed the loaded value; fail_cnt SHALL never exceed MAX_FAIL-1.
REQ-025 Unused state encodings SHALL return to IDLE with reset-value outputs on the next clock.

Reset
REQ-026 While rst=1 at a rising edge: state<=IDLE, unlocked=0, alarm=0, fail_cnt=0, remaining=0; rst takes priority over every other input.
REQ-027 Reset asserted mid-OPEN or mid-LOCKED SHALL abort the countdown with no residual effect after release.

Verification
REQ-028 Good code: attempt_valid=1, attempt_ok=1 in IDLE -> next cycle unlocked=1, remaining=5; after 5 ticks -> unlocked=0, remaining=0, state IDLE.
REQ-029 Lockout: three wrong attempts -> fail_cnt 1, 2, then alarm=1, remaining=10, fail_cnt=0; a correct attempt during LOCKED -> unlocked stays 0; after 10 ticks -> alarm=0.
REQ-030 Counter clear: two wrong attempts then one good -> fail_cnt=2 then unlocked=1, fail_cnt=0; after expiry one wrong attempt -> fail_cnt=1, no alarm.
REQ-031 Simultaneous events: tick=1 in the same cycle as good attempt -> remaining=5 (not 4); relock=1 with tick=1 and remaining=3 in OPEN -> IDLE, remaining=0.
REQ-032 Reset mid-operation: rst=1 while LOCKED with remaining=7 -> next cycle alarm=0, remaining=0, fail_cnt=0; tick afterwards -> outputs unchanged.
REQ-033 Parameter override MAX_FAIL=1, LOCK_SEC=2: one wrong attempt -> alarm=1, remaining=2; two ticks -> alarm=0.
